// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: debug run/step/halt and hazard sequencing for the
// 5-stage core; drives per-stage write/flush controls.
//
// Ports:
//   i_clk, i_rst_n (async, active low)
//   i_start/i_step/i_stop     debug command pulses
//   i_load_use_stall          load-use hazard (ID)
//   i_branch_taken            taken branch/jump (ID)
//   i_muldiv_start            mul/div in EX
//   i_halt                    HALT retiring in WB
//   o_*_write / o_*_flush     stage register controls
//   o_muldiv_done, o_halted, o_state
//   o_stall_cnt, o_flush_cnt  saturating perf counters
//
// Optional: PIPE_SEQ_PERF_EN builds the perf counters; without it
// both counter outputs are tied to zero.
//
// A register being flushed loads a NOP through its flush input, so its
// write enable is held low in that cycle: write and flush of the same
// register are never asserted together.
module pipeline_sequencer #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_stop,
  input  logic             i_load_use_stall,
  input  logic             i_branch_taken,
  input  logic             i_muldiv_start,
  input  logic             i_halt,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_write,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_write,
  output logic             o_ex_mem_flush,
  output logic             o_mem_wb_write,
  output logic             o_muldiv_done,
  output logic             o_halted,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    MULDIV = 3'd3,
    HALTED = 3'd4
  } state_t;

  // Entry cycle plus MULDIV cycles counting LOAD..0 gives MULDIV_LAT.
  localparam logic [7:0] LOAD = 8'(MULDIV_LAT - 2);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] count;
  logic [7:0] count_nxt;

  logic active;
  logic halt_hit;
  logic md_hit;
  logic stall_hit;
  logic flush_hit;

  assign active = (state == RUN) || (state == STEP);

  // One-hot priority resolution for RUN/STEP cycles.
  always_comb begin
    halt_hit  = active & i_halt;
    md_hit    = active & ~i_halt & i_muldiv_start;
    stall_hit = active & ~i_halt & ~i_muldiv_start
              & i_load_use_stall;
    flush_hit = active & ~i_halt & ~i_muldiv_start
              & ~i_load_use_stall & i_branch_taken;
  end

  always_comb begin
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_write  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_write = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_mem_wb_write = 1'b0;
    o_muldiv_done  = 1'b0;
    o_halted       = 1'b0;
    state_nxt      = state;
    count_nxt      = count;
    unique case (state)
      IDLE: begin
        if (i_start) state_nxt = RUN;
        else if (i_step) state_nxt = STEP;
      end
      RUN, STEP: begin
        unique case (1'b1)
          halt_hit: begin
            state_nxt = HALTED;
          end
          md_hit: begin
            o_ex_mem_flush = 1'b1;
            o_mem_wb_write = 1'b1;
            count_nxt      = LOAD;
            state_nxt      = MULDIV;
          end
          stall_hit: begin
            o_id_ex_flush  = 1'b1;
            o_ex_mem_write = 1'b1;
            o_mem_wb_write = 1'b1;
          end
          flush_hit: begin
            o_pc_write     = 1'b1;
            o_if_id_flush  = 1'b1;
            o_id_ex_write  = 1'b1;
            o_ex_mem_write = 1'b1;
            o_mem_wb_write = 1'b1;
          end
          default: begin
            o_pc_write     = 1'b1;
            o_if_id_write  = 1'b1;
            o_id_ex_write  = 1'b1;
            o_ex_mem_write = 1'b1;
            o_mem_wb_write = 1'b1;
          end
        endcase
        if (!halt_hit && !md_hit) begin
          if (state == STEP || i_stop)
            state_nxt = IDLE;
        end
      end
      MULDIV: begin
        if (count == 8'd0) begin
          o_muldiv_done  = 1'b1;
          o_pc_write     = 1'b1;
          o_if_id_write  = 1'b1;
          o_id_ex_write  = 1'b1;
          o_ex_mem_write = 1'b1;
          o_mem_wb_write = 1'b1;
          state_nxt      = RUN;
        end else begin
          o_ex_mem_flush = 1'b1;
          o_mem_wb_write = 1'b1;
          count_nxt      = count - 8'd1;
        end
      end
      HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  assign o_state = state;

`ifdef PIPE_SEQ_PERF_EN
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && stall_cnt != MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_hit && flush_cnt != MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
`else
  logic unused_hits;
  assign unused_hits = stall_hit | flush_hit;
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed + random stimulus against a
// table-driven reference of the sequencer.
module tb_pipeline_sequencer;

  localparam int LAT = 4;
  localparam int CW  = 2;
`ifdef PIPE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  // Control vector order:
  // pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f, mem_wb_w
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_RUN   = 8'b1101_0101;
  localparam logic [7:0] C_HOLD  = 8'b0000_0011;
  localparam logic [7:0] C_STALL = 8'b0000_1101;
  localparam logic [7:0] C_BR    = 8'b1011_0101;

  // Stimulus bit positions in the 7-bit command word.
  localparam int B_START = 6;
  localparam int B_STEP  = 5;
  localparam int B_STOP  = 4;
  localparam int B_LU    = 3;
  localparam int B_BR    = 2;
  localparam int B_MD    = 1;
  localparam int B_HALT  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, step = 1'b0, stop = 1'b0;
  logic lu = 1'b0, br = 1'b0, md = 1'b0, halt = 1'b0;

  logic pc_w, ifid_w, ifid_f, idex_w, idex_f;
  logic exmem_w, exmem_f, memwb_w;
  logic done, halted;
  logic [2:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_sequencer #(
    .MULDIV_LAT(LAT),
    .CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_step(step),
    .i_stop(stop),
    .i_load_use_stall(lu),
    .i_branch_taken(br),
    .i_muldiv_start(md),
    .i_halt(halt),
    .o_pc_write(pc_w),
    .o_if_id_write(ifid_w),
    .o_if_id_flush(ifid_f),
    .o_id_ex_write(idex_w),
    .o_id_ex_flush(idex_f),
    .o_ex_mem_write(exmem_w),
    .o_ex_mem_flush(exmem_f),
    .o_mem_wb_write(memwb_w),
    .o_muldiv_done(done),
    .o_halted(halted),
    .o_state(state),
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: mode 0 idle,1 run,2 step,3 muldiv,4 halted.
  // left = MULDIV cycles still to go, including the current one.
  int m_mode  = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ctrl(input logic [6:0] v);
    if (m_mode == 1 || m_mode == 2) begin
      if (v[B_HALT]) return C_NONE;
      if (v[B_MD])   return C_HOLD;
      if (v[B_LU])   return C_STALL;
      if (v[B_BR])   return C_BR;
      return C_RUN;
    end
    if (m_mode == 3) return (m_left == 1) ? C_RUN : C_HOLD;
    return C_NONE;
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : CMAX;
  endfunction

  task automatic ref_step(input logic [6:0] v);
    case (m_mode)
      0: begin
        if (v[B_START]) m_mode = 1;
        else if (v[B_STEP]) m_mode = 2;
      end
      1, 2: begin
        if (v[B_HALT]) m_mode = 4;
        else if (v[B_MD]) begin
          m_mode = 3;
          m_left = LAT - 1;
        end else begin
          if (v[B_LU]) m_stall = sat(m_stall);
          else if (v[B_BR]) m_flush = sat(m_flush);
          if (m_mode == 2 || v[B_STOP]) m_mode = 0;
        end
      end
      3: begin
        if (m_left == 1) m_mode = 1;
        else m_left--;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input logic [6:0] v);
    logic [7:0] act;
    act = {pc_w, ifid_w, ifid_f, idex_w, idex_f,
           exmem_w, exmem_f, memwb_w};
    check("ctrl", 32'(act), 32'(ref_ctrl(v)));
    check("done", 32'(done),
          32'(m_mode == 3 && m_left == 1));
    check("halted", 32'(halted), 32'(m_mode == 4));
    check("state", 32'(state), 32'(m_mode));
    check("stall_cnt", 32'(stall_cnt),
          PERF ? 32'(m_stall) : 32'd0);
    check("flush_cnt", 32'(flush_cnt),
          PERF ? 32'(m_flush) : 32'd0);
  endtask

  task automatic apply(input logic [6:0] v);
    @(negedge clk);
    {start, step, stop, lu, br, md, halt} = v;
    #1;
    check_outputs(v);
    ref_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    {start, step, stop, lu, br, md, halt} = 7'd0;
    rst_n = 1'b0;
    #1;
    m_mode  = 0;
    m_left  = 0;
    m_stall = 0;
    m_flush = 0;
    check_outputs(7'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [6:0] cmd(input int pos);
    logic [6:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  function automatic logic pick(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  initial begin
    do_reset();
    // start, then plain run
    apply(cmd(B_START));
    apply(7'd0);
    // load-use wins over a taken branch
    apply(cmd(B_LU) | cmd(B_BR));
    apply(cmd(B_BR));
    apply(7'd0);
    // mul/div hold with a stop pulse inside it
    apply(cmd(B_MD));
    apply(cmd(B_STOP));
    apply(7'd0);
    apply(7'd0);
    apply(7'd0);
    check("run_after_hold", 32'(state), 32'd1);
    // stop back to idle, then single step
    apply(cmd(B_STOP));
    apply(cmd(B_STEP));
    apply(7'd0);
    apply(7'd0);
    check("idle_after_step", 32'(state), 32'd0);
    // halt beats mul/div; start ignored while halted
    apply(cmd(B_START));
    apply(cmd(B_HALT) | cmd(B_MD));
    apply(cmd(B_START));
    apply(7'd0);
    do_reset();
    // counter saturation
    apply(cmd(B_START));
    for (int i = 0; i < 5; i++) apply(cmd(B_LU));
    check("stall_sat", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
    apply(7'd0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] v;
      if ((m_mode == 4 && pick(15)) || pick(1)) begin
        do_reset();
      end else begin
        v[B_START] = pick(10);
        v[B_STEP]  = pick(10);
        v[B_STOP]  = pick(8);
        v[B_LU]    = pick(25);
        v[B_BR]    = pick(25);
        v[B_MD]    = pick(5);
        v[B_HALT]  = pick(2);
        apply(v);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
